spi_flash_cmd_sequencer: RTL
============================

Name: spi_flash_cmd_sequencer

Overview:
Command-level controller for the SPI flash port. It accepts one command at a time: opcode, optional 24-bit address and read length. It then sequences chip select and a byte-level SPI shift engine through the opcode, address and read phases. It sits between the system-side requesters (RDID, READ, RDSR, WREN users) and the byte shifter, and owns CS timing and byte ordering.

Parameters:
LEN_W, 8, width of read-length field; max read = 2^LEN_W-1 bytes
CS_SETUP_CYC, 2, clk cycles cs_n low before first byte start (>=1)
CS_HOLD_CYC, 2, clk cycles after last byte done before cs_n high (>=1)
CS_IDLE_CYC, 4, minimum clk cycles cs_n high before next command accepted (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer can accept a command
cmd_opcode  in  8  instruction byte
cmd_has_addr  in  1  send 3 address bytes after opcode
cmd_addr  in  24  flash address, sent MSB byte first
cmd_rd_len  in  LEN_W  number of read bytes; 0 = no read phase
rd_data  out  8  received read byte
rd_valid  out  1  one-cycle strobe per read byte, no backpressure
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle pulse when command completes
spi_cs_n  out  1  flash chip select, active low
xfer_start  out  1  one-cycle pulse: shift xfer_tx
xfer_tx  out  8  byte to shift out; stable from xfer_start until xfer_done
xfer_done  in  1  one-cycle pulse from shifter: byte complete
xfer_rx  in  8  byte shifted in, valid with xfer_done

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: spi_cs_n=1, xfer_start=0, xfer_tx=0, rd_valid=0, rd_data=0, done=0, busy=0. State=IDLE, so cmd_ready=1.
- cmd_ready = (state==IDLE), combinational. Accept on the clk edge where cmd_valid&&cmd_ready. Latch opcode, has_addr, addr and rd_len at that edge. Later input changes are ignored.
- States: IDLE -> CS_SETUP -> OPCODE -> [ADDR] -> [READ] -> CS_HOLD -> CS_GAP -> IDLE.
- CS_SETUP: spi_cs_n goes low on the accept edge. The state lasts exactly CS_SETUP_CYC cycles.
- Byte phases (OPCODE/ADDR/READ): xfer_start is a registered pulse, high for the first cycle of each byte. The sequencer then waits for xfer_done with any latency >=1 cycle. Only one byte is outstanding at a time. The next byte's xfer_start is asserted the cycle after xfer_done.
- OPCODE sends cmd_opcode. Next state is ADDR if has_addr, else READ if rd_len!=0, else CS_HOLD.
- ADDR sends addr[23:16], addr[15:8], addr[7:0], tracked by a 2-bit byte counter. Next state is READ if rd_len!=0, else CS_HOLD.
- READ sends xfer_tx=8'h00 as a dummy byte. Each xfer_done produces rd_valid=1 and rd_data=xfer_rx in the next cycle (registered). A down-counter loaded with rd_len is decremented per byte. Leave READ on the xfer_done that brings the counter to 0.
- CS_HOLD lasts CS_HOLD_CYC cycles with cs_n low. On exit, spi_cs_n goes high and done pulses in the same cycle.
- CS_GAP lasts CS_IDLE_CYC cycles with cs_n high and cmd_ready=0.
- xfer_done received while no byte is outstanding is ignored, with no state change.
- Max rd_len = 2^LEN_W-1. Counter width is LEN_W and it never wraps.
- Reset mid-command: at the reset edge, spi_cs_n returns to 1 and all strobes clear. A xfer_done arriving after reset is ignored. The shifter is reset by the same reset.
- cmd_valid held high while busy is not an error. The command is simply not accepted until cmd_ready.

Decomposition:
- Package spi_flash_pkg holds:
  - opcode constants RDID=8'h9F, READ=8'h03, RDSR=8'h05, WREN=8'h06;
  - state encoding localparams;
  - ADDR_BYTES=3.
- One natural sub-module: spi_cs_timer, a loadable down-counter with a zero flag. It is reused for the CS_SETUP, CS_HOLD and CS_GAP delays.
- The byte shifter is a separate existing block and is not instantiated here.

Test Plan:
- Test setup: shifter model returns xfer_done 3 cycles after xfer_start, with xfer_rx from a script.
- RDID: opcode 8'h9F, has_addr=0, rd_len=3, rx script EF,40,18 -> tx bytes are 9F,00,00,00. rd_data is EF,40,18 with exactly 3 rd_valid. cs_n is low for CS_SETUP+4 bytes+CS_HOLD. There is one done pulse.
- WREN: opcode 8'h06, has_addr=0, rd_len=0 -> one xfer_start only, no rd_valid. done fires the cycle cs_n rises. cmd_ready returns CS_IDLE_CYC cycles later.
- READ: opcode 8'h03, addr=24'h12_34_56, rd_len=2 -> tx sequence is 03,12,34,56,00,00 and exactly 2 rd_valid.
- Back-to-back: cmd_valid held high with two RDSR commands -> the second is accepted only after CS_GAP, and cs_n stays high >= CS_IDLE_CYC cycles between them.
- Reset asserted during the second address byte -> the next cycle has cs_n=1, busy=0, cmd_ready=1. The late xfer_done is ignored, with no rd_valid and no done.
- A spurious xfer_done in IDLE is ignored. A variable shifter latency (1 to 7 cycles) keeps the byte order and counts correct.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash command sequencer.
package spi_flash_pkg;

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    localparam int ADDR_BYTES = 3;
    localparam int TIMER_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_OPCODE   = 3'd2,
        ST_ADDR     = 3'd3,
        ST_READ     = 3'd4,
        ST_CS_HOLD  = 3'd5,
        ST_CS_GAP   = 3'd6
    } seq_state_e;

    // Address goes out MSB byte first: index 0 is addr[23:16].
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
        case (idx)
            2'd0:    addr_byte = addr[23:16];
            2'd1:    addr_byte = addr[15:8];
            default: addr_byte = addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_cmd_sequencer_cs_timer.sv
// Loadable down-counter with zero flag; times the CS setup, hold and idle gaps.
module spi_cs_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_flash_cmd_sequencer.sv
// Command-level SPI flash controller: sequences chip select and a byte shifter through
// opcode, address and read phases. Handshake: a command transfers on the edge where valid && ready.
module spi_flash_cmd_sequencer
    import spi_flash_pkg::*;
#(
    parameter int LEN_W        = 8,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int CS_IDLE_CYC  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [7:0]       cmd_opcode_i,
    input  logic             cmd_has_addr_i,
    input  logic [23:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_rd_len_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             spi_cs_n_o,
    output logic             xfer_start_o,
    output logic [7:0]       xfer_tx_o,
    input  logic             xfer_done_i,
    input  logic [7:0]       xfer_rx_i,
    output seq_state_e       state_o
);

    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(CS_SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(CS_HOLD_CYC - 1);
    localparam logic [TIMER_W-1:0] IDLE_LOAD  = TIMER_W'(CS_IDLE_CYC - 1);
    localparam logic [1:0]         LAST_ADDR  = 2'(ADDR_BYTES - 1);

    seq_state_e       state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             has_addr_q, has_addr_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             cs_n_q, cs_n_d;
    logic             start_q, start_d;
    logic [7:0]       tx_q, tx_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             done_q, done_d;
    logic             timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic             timer_zero;

    spi_cs_timer #(.W(TIMER_W)) u_cs_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        has_addr_d = has_addr_q;
        addr_d     = addr_q;
        rd_cnt_d   = rd_cnt_q;
        byte_cnt_d = byte_cnt_q;
        cs_n_d     = cs_n_q;
        tx_d       = tx_q;
        rd_data_d  = rd_data_q;
        start_d    = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    opcode_d   = cmd_opcode_i;
                    has_addr_d = cmd_has_addr_i;
                    addr_d     = cmd_addr_i;
                    rd_cnt_d   = cmd_rd_len_i;
                    cs_n_d     = 1'b0;
                    timer_load = 1'b1;
                    timer_val  = SETUP_LOAD;
                    state_d    = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (timer_zero) begin
                    start_d = 1'b1;
                    tx_d    = opcode_q;
                    state_d = ST_OPCODE;
                end
            end
            ST_OPCODE: begin
                if (xfer_done_i) begin
                    if (has_addr_q) begin
                        start_d    = 1'b1;
                        tx_d       = addr_byte(addr_q, 2'd0);
                        byte_cnt_d = 2'd0;
                        state_d    = ST_ADDR;
                    end else if (rd_cnt_q != '0) begin
                        start_d = 1'b1;
                        tx_d    = 8'h00;
                        state_d = ST_READ;
                    end else begin
                        timer_load = 1'b1;
                        timer_val  = HOLD_LOAD;
                        state_d    = ST_CS_HOLD;
                    end
                end
            end
            ST_ADDR: begin
                if (xfer_done_i) begin
                    if (byte_cnt_q != LAST_ADDR) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        start_d    = 1'b1;
                        tx_d       = addr_byte(addr_q, byte_cnt_q + 2'd1);
                    end else if (rd_cnt_q != '0) begin
                        start_d = 1'b1;
                        tx_d    = 8'h00;
                        state_d = ST_READ;
                    end else begin
                        timer_load = 1'b1;
                        timer_val  = HOLD_LOAD;
                        state_d    = ST_CS_HOLD;
                    end
                end
            end
            ST_READ: begin
                // Entered only with a non-zero count, so the decrement never wraps.
                if (xfer_done_i) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = xfer_rx_i;
                    rd_cnt_d   = rd_cnt_q - 1'b1;
                    if (rd_cnt_q == LEN_W'(1)) begin
                        timer_load = 1'b1;
                        timer_val  = HOLD_LOAD;
                        state_d    = ST_CS_HOLD;
                    end else begin
                        start_d = 1'b1;
                        tx_d    = 8'h00;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (timer_zero) begin
                    cs_n_d     = 1'b1;
                    done_d     = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = IDLE_LOAD;
                    state_d    = ST_CS_GAP;
                end
            end
            ST_CS_GAP: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            has_addr_q <= 1'b0;
            addr_q     <= '0;
            rd_cnt_q   <= '0;
            byte_cnt_q <= '0;
            cs_n_q     <= 1'b1;
            start_q    <= 1'b0;
            tx_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            has_addr_q <= has_addr_d;
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            cs_n_q     <= cs_n_d;
            start_q    <= start_d;
            tx_q       <= tx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign spi_cs_n_o   = cs_n_q;
    assign xfer_start_o = start_q;
    assign xfer_tx_o    = tx_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign state_o      = state_q;

endmodule
